// File: rtl/obi_credit_arbiter.sv
// OBI N:1 arbiter: two-class round-robin with per-port outstanding credits and in-order response routing.
// Optional starvation guard via wait counters when OBI_CREDIT_ARB_AGING_EN is defined.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   1,
    UseRReady: 1'b0
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

module obi_credit_arbiter
  import obi_pkg::*;
#(
  parameter obi_cfg_t    SbrPortObiCfg      = ObiDefaultConfig,
  parameter obi_cfg_t    MgrPortObiCfg      = SbrPortObiCfg,
  parameter type         sbr_port_obi_req_t = obi_req_t,
  parameter type         sbr_port_a_chan_t  = obi_a_chan_t,
  parameter type         sbr_port_obi_rsp_t = obi_rsp_t,
  parameter type         sbr_port_r_chan_t  = obi_r_chan_t,
  parameter type         mgr_port_obi_req_t = sbr_port_obi_req_t,
  parameter type         mgr_port_obi_rsp_t = sbr_port_obi_rsp_t,
  parameter int unsigned NumSbrPorts        = 2,
  parameter int unsigned NumMaxTrans        = 4,
  parameter int unsigned MaxTransPerPort    = 2,
  parameter int unsigned AgeThreshold       = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  sbr_port_obi_req_t                  sbr_ports_obi_req_i [NumSbrPorts],
  output sbr_port_obi_rsp_t                  sbr_ports_obi_rsp_o [NumSbrPorts],
  output mgr_port_obi_req_t                  mgr_port_obi_req_o,
  input  mgr_port_obi_rsp_t                  mgr_port_obi_rsp_i,
  input  logic [NumSbrPorts-1:0]             prio_i,
  output logic [$clog2(NumMaxTrans+1)-1:0]   outstanding_o
);

  localparam int unsigned IdxW = $clog2(NumSbrPorts);
  localparam int unsigned CntW = $clog2(MaxTransPerPort + 1);
  localparam int unsigned OccW = $clog2(NumMaxTrans + 1);
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam bit          UseRReady = SbrPortObiCfg.UseRReady;

  if (NumSbrPorts < 2) begin : g_chk_ports
    $fatal(1, "obi_credit_arbiter: NumSbrPorts must be at least 2");
  end
  if (NumMaxTrans < 1) begin : g_chk_trans
    $fatal(1, "obi_credit_arbiter: NumMaxTrans must be at least 1");
  end
  if (MaxTransPerPort < 1 || MaxTransPerPort > NumMaxTrans) begin : g_chk_per_port
    $fatal(1, "obi_credit_arbiter: MaxTransPerPort must lie in 1..NumMaxTrans");
  end
  if (AgeThreshold < 1) begin : g_chk_age
    $fatal(1, "obi_credit_arbiter: AgeThreshold must be at least 1");
  end
  if (MgrPortObiCfg.IdWidth != SbrPortObiCfg.IdWidth) begin : g_chk_id
    $fatal(1, "obi_credit_arbiter: IdWidth must match between ports");
  end

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [CntW-1:0]   cnt_q [NumSbrPorts];

  logic [IdxW-1:0]   idx_mem [NumMaxTrans];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]   count_q;

  logic [NumSbrPorts-1:0] elig, hi, cand, aged;
  logic [IdxW-1:0]   rr_win, sel, head;
  logic              sel_valid, mgr_req, hs, push, pop;
  logic              fifo_full, fifo_empty, head_rready;
  sbr_port_a_chan_t  sel_a;
  sbr_port_r_chan_t  mgr_r;

  assign fifo_full   = (count_q == OccW'(NumMaxTrans));
  assign fifo_empty  = (count_q == '0);
  assign head        = idx_mem[rd_ptr_q];
  assign head_rready = sbr_ports_obi_req_i[head].rready;

  always_comb begin
    elig = '0;
    hi   = '0;
    for (int i = 0; i < NumSbrPorts; i++) begin
      elig[i] = sbr_ports_obi_req_i[i].req && (cnt_q[i] < CntW'(MaxTransPerPort));
      hi[i]   = elig[i] && (prio_i[i] || aged[i]);
    end
  end

  // Round-robin search starting at rr_ptr_q within the active class.
  always_comb begin
    int idx;
    logic found;
    cand   = (|hi) ? hi : elig;
    rr_win = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NumSbrPorts; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NumSbrPorts)) idx = idx - int'(NumSbrPorts);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        rr_win = IdxW'(idx);
      end
    end
  end

  assign sel       = (state_q == LOCKED) ? lock_idx_q : rr_win;
  assign sel_valid = (state_q == LOCKED) ? elig[lock_idx_q] : (|elig);
  assign mgr_req   = sel_valid && !fifo_full;
  assign hs        = mgr_req && mgr_port_obi_rsp_i.gnt;
  assign push      = hs;
  assign pop       = mgr_port_obi_rsp_i.rvalid && !fifo_empty && (!UseRReady || head_rready);
  assign sel_a     = sbr_ports_obi_req_i[sel].a;
  assign mgr_r     = mgr_port_obi_rsp_i.r;

  // Lock the address phase once presented but not yet granted.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      UNLOCKED: begin
        if (mgr_req && !mgr_port_obi_rsp_i.gnt) begin
          state_d    = LOCKED;
          lock_idx_d = rr_win;
        end
      end
      LOCKED: begin
        if (hs) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      if (hs) rr_ptr_q <= (sel == IdxW'(NumSbrPorts - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NumMaxTrans; i++) idx_mem[i] <= '0;
      for (int i = 0; i < NumSbrPorts; i++) cnt_q[i] <= '0;
    end else begin
      if (push) begin
        idx_mem[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + OccW'(push) - OccW'(pop);
      for (int i = 0; i < NumSbrPorts; i++) begin
        cnt_q[i] <= cnt_q[i] + CntW'(push && (sel == IdxW'(i)))
                             - CntW'(pop && (head == IdxW'(i)));
      end
    end
  end

`ifdef OBI_CREDIT_ARB_AGING_EN
  localparam int unsigned WaitW = $clog2(AgeThreshold + 1);
  logic [WaitW-1:0] wait_q [NumSbrPorts];

  // Saturating wait counters promote a starved port until it wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSbrPorts; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumSbrPorts; i++) begin
        if (hs && (sel == IdxW'(i))) wait_q[i] <= '0;
        else if (elig[i] && (wait_q[i] != WaitW'(AgeThreshold))) wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int i = 0; i < NumSbrPorts; i++) aged[i] = (wait_q[i] == WaitW'(AgeThreshold));
  end
`else
  assign aged = '0;
`endif

  always_comb begin
    mgr_port_obi_req_o        = '0;
    mgr_port_obi_req_o.a      = sel_a;
    mgr_port_obi_req_o.req    = mgr_req;
    mgr_port_obi_req_o.rready = UseRReady ? (fifo_empty || head_rready) : 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NumSbrPorts; i++) begin
      sbr_ports_obi_rsp_o[i]     = '0;
      sbr_ports_obi_rsp_o[i].gnt = hs && rst_ni && (sel == IdxW'(i));
      if (!fifo_empty && (head == IdxW'(i))) begin
        sbr_ports_obi_rsp_o[i].r      = mgr_r;
        sbr_ports_obi_rsp_o[i].rvalid = mgr_port_obi_rsp_i.rvalid && rst_ni;
      end
    end
  end

  assign outstanding_o = count_q;

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mgr_port_obi_rsp_i.rvalid && fifo_empty))
    else $error("obi_credit_arbiter: rvalid with no outstanding transaction");

endmodule

// File: tb/tb_obi_credit_arbiter.sv
// Directed self-checking bench for obi_credit_arbiter with four ports, FIFO depth 4, two credits per port.
// Aging expectations follow OBI_CREDIT_ARB_AGING_EN.
module tb_obi_credit_arbiter;
  import obi_pkg::*;

  localparam int unsigned NPorts = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  obi_req_t   sbr_req [NPorts];
  obi_rsp_t   sbr_rsp [NPorts];
  obi_req_t   mgr_req;
  obi_rsp_t   mgr_rsp;
  logic [3:0] prio;
  logic [2:0] outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_credit_arbiter #(
    .NumSbrPorts     (NPorts),
    .NumMaxTrans     (4),
    .MaxTransPerPort (2),
    .AgeThreshold    (8)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .sbr_ports_obi_req_i (sbr_req),
    .sbr_ports_obi_rsp_o (sbr_rsp),
    .mgr_port_obi_req_o  (mgr_req),
    .mgr_port_obi_rsp_i  (mgr_rsp),
    .prio_i              (prio),
    .outstanding_o       (outstanding)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqs, input logic [3:0] prios,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata);
    for (int i = 0; i < NPorts; i++) sbr_req[i].req = reqs[i];
    prio            = prios;
    mgr_rsp.gnt     = gnt;
    mgr_rsp.rvalid  = rvalid;
    mgr_rsp.r.rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [3:0] gnt_vec();
    logic [3:0] v;
    for (int i = 0; i < NPorts; i++) v[i] = sbr_rsp[i].gnt;
    return v;
  endfunction

  function automatic logic [3:0] rvalid_vec();
    logic [3:0] v;
    for (int i = 0; i < NPorts; i++) v[i] = sbr_rsp[i].rvalid;
    return v;
  endfunction

  initial begin
    int first_p1;
    int p0_early;
    int over;
    logic [3:0] g;

    mgr_rsp = '0;
    for (int i = 0; i < NPorts; i++) begin
      sbr_req[i]        = '0;
      sbr_req[i].a.addr = 32'h1000 + 32'(i) * 32'h100;
      sbr_req[i].rready = 1'b1;
    end

    // Outputs while held in reset.
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
    #2;
    checkOutput("rst_mgr_req", mgr_req.req, 1'b1);
    checkOutput("rst_gnt", gnt_vec(), 4'b0000);
    checkOutput("rst_outstanding", outstanding, 3'd0);
    do_reset();

    // Two ports alternate with responses one cycle later.
    next_cycle(); applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("alt_a_gnt", gnt_vec(), 4'b0001);
    checkOutput("alt_a_addr", mgr_req.a.addr, 32'h1000);
    next_cycle(); applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b1, 32'hA0); #2;
    checkOutput("alt_b_gnt", gnt_vec(), 4'b0010);
    checkOutput("alt_b_addr", mgr_req.a.addr, 32'h1100);
    checkOutput("alt_b_rvalid", rvalid_vec(), 4'b0001);
    checkOutput("alt_b_rdata", sbr_rsp[0].r.rdata, 32'hA0);
    checkOutput("alt_b_outstanding", outstanding, 3'd1);
    next_cycle(); applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b1, 32'hB1); #2;
    checkOutput("alt_c_gnt", gnt_vec(), 4'b0001);
    checkOutput("alt_c_rvalid", rvalid_vec(), 4'b0010);
    checkOutput("alt_c_rdata1", sbr_rsp[1].r.rdata, 32'hB1);
    checkOutput("alt_c_rdata0", sbr_rsp[0].r.rdata, 32'h0);
    next_cycle(); applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b1, 32'hA2); #2;
    checkOutput("alt_d_gnt", gnt_vec(), 4'b0010);
    checkOutput("alt_d_rvalid", rvalid_vec(), 4'b0001);
    next_cycle(); applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 32'hB3); #2;
    checkOutput("alt_e_mgr_req", mgr_req.req, 1'b0);
    checkOutput("alt_e_rvalid", rvalid_vec(), 4'b0010);
    next_cycle(); applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0); #2;
    checkOutput("alt_f_outstanding", outstanding, 3'd0);

    // Per-port credit limit, then freed credit reused next cycle.
    do_reset();
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("cred_1_gnt", gnt_vec(), 4'b0001);
    next_cycle(); #2;
    checkOutput("cred_2_gnt", gnt_vec(), 4'b0001);
    next_cycle(); #2;
    checkOutput("cred_3_mgr_req", mgr_req.req, 1'b0);
    checkOutput("cred_3_gnt", gnt_vec(), 4'b0000);
    checkOutput("cred_3_outstanding", outstanding, 3'd2);
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 32'h33); #2;
    checkOutput("cred_4_rvalid", rvalid_vec(), 4'b0001);
    checkOutput("cred_4_mgr_req", mgr_req.req, 1'b0);
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("cred_5_gnt", gnt_vec(), 4'b0001);
    checkOutput("cred_5_outstanding", outstanding, 3'd1);
    next_cycle(); applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0); #2;
    checkOutput("cred_6_outstanding", outstanding, 3'd2);

    // Ungranted address phase stays locked on port 0 despite a priority request.
    do_reset();
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 32'h0); #2;
    checkOutput("lock_1_addr", mgr_req.a.addr, 32'h1000);
    checkOutput("lock_1_req", mgr_req.req, 1'b1);
    for (int c = 2; c <= 3; c++) begin
      next_cycle(); applyStimulus(4'b0011, 4'b0010, 1'b0, 1'b0, 32'h0); #2;
      checkOutput($sformatf("lock_%0d_addr", c), mgr_req.a.addr, 32'h1000);
      checkOutput($sformatf("lock_%0d_gnt", c), gnt_vec(), 4'b0000);
    end
    next_cycle(); applyStimulus(4'b0011, 4'b0010, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("lock_4_gnt", gnt_vec(), 4'b0001);
    checkOutput("lock_4_addr", mgr_req.a.addr, 32'h1000);
    next_cycle(); #2;
    checkOutput("lock_5_gnt", gnt_vec(), 4'b0010);

    // Shared FIFO fills at four, one response frees a slot.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle(); applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
      checkOutput($sformatf("full_gnt_%0d", c), gnt_vec(), 4'b0001 << c);
    end
    next_cycle(); #2;
    checkOutput("full_mgr_req", mgr_req.req, 1'b0);
    checkOutput("full_gnt_blocked", gnt_vec(), 4'b0000);
    checkOutput("full_outstanding", outstanding, 3'd4);
    next_cycle(); applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1, 32'h55); #2;
    checkOutput("full_rvalid", rvalid_vec(), 4'b0001);
    checkOutput("full_rdata0", sbr_rsp[0].r.rdata, 32'h55);
    checkOutput("full_rdata1", sbr_rsp[1].r.rdata, 32'h0);
    next_cycle(); applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("full_after_outstanding", outstanding, 3'd3);
    checkOutput("full_after_gnt", gnt_vec(), 4'b0001);

    // Asynchronous reset mid-operation clears occupancy at once.
    next_cycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outstanding", outstanding, 3'd0);
    checkOutput("midrst_gnt", gnt_vec(), 4'b0000);
    checkOutput("midrst_mgr_req", mgr_req.req, 1'b1);
    do_reset();

    // Same-cycle grant and response on port 0 leave its credit count alone.
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("same_1_gnt", gnt_vec(), 4'b0001);
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 32'h77); #2;
    checkOutput("same_2_gnt", gnt_vec(), 4'b0001);
    checkOutput("same_2_rvalid", rvalid_vec(), 4'b0001);
    checkOutput("same_2_outstanding", outstanding, 3'd1);
    next_cycle(); applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0); #2;
    checkOutput("same_3_outstanding", outstanding, 3'd1);
    checkOutput("same_3_gnt", gnt_vec(), 4'b0001);
    next_cycle(); #2;
    checkOutput("same_4_mgr_req", mgr_req.req, 1'b0);
    checkOutput("same_4_outstanding", outstanding, 3'd2);

    // Continuous high-priority port 0 against low-priority port 1.
    do_reset();
    first_p1 = 0;
    p0_early = 0;
    over     = 0;
    for (int c = 1; c <= 100; c++) begin
      next_cycle(); applyStimulus(4'b0011, 4'b0001, 1'b1, c > 1, 32'(c)); #2;
      g = gnt_vec();
      if (g[1] && first_p1 == 0) first_p1 = c;
      if (c <= 8 && g[0]) p0_early++;
      if (outstanding > 3'd1) over++;
    end
    checkOutput("age_p0_early", p0_early, 8);
    checkOutput("age_outstanding", over, 0);
`ifdef OBI_CREDIT_ARB_AGING_EN
    checkOutput("age_p1_first", first_p1, 9);
`else
    checkOutput("age_p1_starved", first_p1, 0);
`endif

    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
